// File: rtl/knl_packet_tx_if.sv
// Handshake and serial-line bundle for the KNL frame transmitter.
// The master side drives the payload request; the slave side is the transmitter.
interface knl_packet_tx_if #(
    parameter int DATA_W = 8
);
    localparam int LEN_W = $clog2(DATA_W + 1);

    logic              start;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic              ready;
    logic              busy;
    logic              dataOut;
    logic              frameDone;

    modport master (
        output start, data, len,
        input  ready, busy, dataOut, frameDone
    );

    modport slave (
        input  start, data, len,
        output ready, busy, dataOut, frameDone
    );
endinterface

// File: rtl/knl_packet_tx.sv
// KNL single-wire frame transmitter: preamble of ones, zero-stuffed payload, trailer of zeros.
// Optional even-parity bit after the payload when KNL_TX_PARITY_EN is defined.
module knl_packet_tx #(
    parameter int DATA_W    = 8,
    parameter int PRE_LEN   = 4,
    parameter int TRAIL_LEN = 3
) (
    input logic             clk,
    input logic             reset,
    knl_packet_tx_if.slave  bus
);
    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam int PRE_W = $clog2(PRE_LEN) + 1;
    localparam int TRL_W = $clog2(TRAIL_LEN) + 1;

    typedef enum logic [2:0] {IDLE, PRE, BODY, STUFF, PARITY, TRAIL, DONE} state_t;

    state_t            state;
    state_t            tail_state;
    logic              tail_bit;
    logic [DATA_W-1:0] sh;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  len_c;
    logic              empty;
    logic [PRE_W-1:0]  pre_cnt;
    logic [TRL_W-1:0]  trl_cnt;
    logic              data_out;
    logic              ready;
    logic              busy;
    logic              frame_done;

`ifdef KNL_TX_PARITY_EN
    logic par_bit;
    logic par_done;

    function automatic logic [DATA_W-1:0] len_mask(input logic [LEN_W-1:0] n);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) m[i] = (i < int'(n));
        return m;
    endfunction
`endif

    always_comb begin
        len_c = (bus.len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : bus.len;
    end

    // What follows the last payload bit (or an empty payload).
    always_comb begin
`ifdef KNL_TX_PARITY_EN
        tail_state = PARITY;
        tail_bit   = par_bit;
`else
        tail_state = TRAIL;
        tail_bit   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sh         <= '0;
            idx        <= '0;
            empty      <= 1'b0;
            pre_cnt    <= '0;
            trl_cnt    <= '0;
            data_out   <= 1'b0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef KNL_TX_PARITY_EN
            par_bit    <= 1'b0;
            par_done   <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                // DONE is the frameDone cycle; it accepts a start just like IDLE.
                IDLE, DONE: begin
                    state    <= IDLE;
                    data_out <= 1'b0;
                    ready    <= 1'b1;
                    busy     <= 1'b0;
                    if (bus.start) begin
                        state    <= PRE;
                        data_out <= 1'b1;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                        pre_cnt  <= PRE_W'(1);
                        // Left-align so the first payload bit sits at the MSB.
                        sh       <= bus.data << (DATA_W - int'(len_c));
                        idx      <= len_c - LEN_W'(1);
                        empty    <= (len_c == '0);
`ifdef KNL_TX_PARITY_EN
                        par_bit  <= ^(bus.data & len_mask(len_c));
                        par_done <= 1'b0;
`endif
                    end
                end
                PRE: begin
                    if (pre_cnt == PRE_W'(PRE_LEN)) begin
                        if (empty) begin
                            state    <= tail_state;
                            data_out <= tail_bit;
                            trl_cnt  <= TRL_W'(1);
                        end else begin
                            state    <= BODY;
                            data_out <= sh[DATA_W-1];
                            sh       <= sh << 1;
                        end
                    end else begin
                        pre_cnt <= pre_cnt + PRE_W'(1);
                    end
                end
                BODY: begin
                    if (!data_out) begin
                        state    <= STUFF;
                        data_out <= 1'b1;
                    end else if (idx == '0) begin
                        state    <= tail_state;
                        data_out <= tail_bit;
                        trl_cnt  <= TRL_W'(1);
                    end else begin
                        idx      <= idx - LEN_W'(1);
                        data_out <= sh[DATA_W-1];
                        sh       <= sh << 1;
                    end
                end
                STUFF: begin
`ifdef KNL_TX_PARITY_EN
                    if (par_done) begin
                        state    <= TRAIL;
                        data_out <= 1'b0;
                        trl_cnt  <= TRL_W'(1);
                    end else
`endif
                    if (idx == '0) begin
                        state    <= tail_state;
                        data_out <= tail_bit;
                        trl_cnt  <= TRL_W'(1);
                    end else begin
                        state    <= BODY;
                        idx      <= idx - LEN_W'(1);
                        data_out <= sh[DATA_W-1];
                        sh       <= sh << 1;
                    end
                end
`ifdef KNL_TX_PARITY_EN
                PARITY: begin
                    par_done <= 1'b1;
                    if (!data_out) begin
                        state    <= STUFF;
                        data_out <= 1'b1;
                    end else begin
                        state    <= TRAIL;
                        data_out <= 1'b0;
                        trl_cnt  <= TRL_W'(1);
                    end
                end
`endif
                TRAIL: begin
                    data_out <= 1'b0;
                    if (trl_cnt == TRL_W'(TRAIL_LEN)) begin
                        state      <= DONE;
                        ready      <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        trl_cnt <= trl_cnt + TRL_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    data_out <= 1'b0;
                    ready    <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dataOut   = data_out;
    assign bus.ready     = ready;
    assign bus.busy      = busy;
    assign bus.frameDone = frame_done;
endmodule

// File: tb/tb_knl_packet_tx.sv
// Directed bench for knl_packet_tx: table of frames sent back-to-back plus
// hand sequences for held start and mid-frame reset.
module tb_knl_packet_tx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    knl_packet_tx_if #(.DATA_W(8)) bus();

    knl_packet_tx #(.DATA_W(8), .PRE_LEN(4), .TRAIL_LEN(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [3:0] len;
        string      body;
        string      par;
    } vec_t;

    vec_t vecs[9];
    int   tests  = 0;
    int   errors = 0;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_s(input string name, input string got, input string want);
        tests++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %s want %s", name, got, want);
        end
    endtask

    function automatic string frame(input string body, input string par);
`ifdef KNL_TX_PARITY_EN
        return {"1111", body, par, "000"};
`else
        return {"1111", body, "000"};
`endif
    endfunction

    // Entered at a negedge with ready high; returns at the negedge of the frameDone cycle.
    task automatic send(input string name, input logic [7:0] d, input logic [3:0] l,
                        input string exp, input bit hold);
        string got = "";
        int    bad = 0;
        bus.start = 1'b1;
        bus.data  = d;
        bus.len   = l;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        bus.data = 8'($urandom);
        bus.len  = 4'($urandom);
        for (int k = 0; k < exp.len(); k++) begin
            if (bus.dataOut) got = {got, "1"};
            else             got = {got, "0"};
            if (!bus.busy || bus.ready || bus.frameDone) bad++;
            @(negedge clk);
        end
        check_s({name, " stream"}, got, exp);
        check({name, " busy/ready in frame"}, bad, 0);
        check({name, " done cycle {fd,rdy,busy,dout}"},
              int'({bus.frameDone, bus.ready, bus.busy, bus.dataOut}), int'(4'b1100));
    endtask

    initial begin
        int bad;
        vecs[0] = '{"A5",   8'hA5, 4'd8,  "101101011011",     "01"};
        vecs[1] = '{"len0", 8'h5A, 4'd0,  "",                 "01"};
        vecs[2] = '{"00",   8'h00, 4'd8,  "0101010101010101", "01"};
        vecs[3] = '{"FF",   8'hFF, 4'd8,  "11111111",         "01"};
        vecs[4] = '{"02l2", 8'h02, 4'd2,  "101",              "1"};
        vecs[5] = '{"clamp",8'hFF, 4'd12, "11111111",         "01"};
        vecs[6] = '{"80l1", 8'h80, 4'd1,  "01",               "01"};
        vecs[7] = '{"03",   8'h03, 4'd8,  "01010101010111",   "01"};
        vecs[8] = '{"07l3", 8'h07, 4'd3,  "111",              "1"};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.data  = '0;
        bus.len   = '0;
        @(negedge clk);
        check("reset state {fd,rdy,busy,dout}",
              int'({bus.frameDone, bus.ready, bus.busy, bus.dataOut}), int'(4'b0100));
        reset = 1'b1;

        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.dataOut || !bus.ready || bus.busy || bus.frameDone) bad++;
        end
        check("idle 10 cycles", bad, 0);

        // Each frame starts in the previous frame's frameDone cycle.
        for (int i = 0; i < 9; i++)
            send(vecs[i].name, vecs[i].data, vecs[i].len, frame(vecs[i].body, vecs[i].par), 1'b0);
        @(negedge clk);
        check("after table {fd,rdy,busy,dout}",
              int'({bus.frameDone, bus.ready, bus.busy, bus.dataOut}), int'(4'b0100));

        send("held start", 8'hA5, 4'd8, frame("101101011011", "01"), 1'b1);
        bus.start = 1'b0;
        @(negedge clk);
        check("held start not queued {fd,rdy,busy,dout}",
              int'({bus.frameDone, bus.ready, bus.busy, bus.dataOut}), int'(4'b0100));

        bus.start = 1'b1;
        bus.data  = 8'hA5;
        bus.len   = 4'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid-body dataOut", int'(bus.dataOut), 0);
        check("mid-body busy", int'(bus.busy), 1);
        #2 reset = 1'b0;
        #1;
        check("async reset {fd,rdy,busy,dout}",
              int'({bus.frameDone, bus.ready, bus.busy, bus.dataOut}), int'(4'b0100));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send("post reset", 8'h02, 4'd2, frame("101", "1"), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/knl_packet_tx.md
Name: knl_packet_tx

Overview:
Serial transmitter for the KNL single-wire framing; it is the sending end of the link whose receiver is the team's KNL detector block. It accepts a payload word over a ready/start handshake and serialises one frame onto dataOut, one bit per clk. Each frame is a run of ones as a preamble, a bit-stuffed payload, and a trailer of zeros. No in-frame pattern contains two consecutive zeros, so the receiver sees a clean begin and a single end.

Parameters:
DATA_W, 8, payload register width in bits (1..32)
PRE_LEN, 4, preamble length in ones; must be >= 4 so the receiver reaches its begin state
TRAIL_LEN, 3, trailer length in zeros; must be >= 3 so the receiver emits end and returns to idle

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
start  input  1  frame request; sampled only while ready=1
data  input  DATA_W  payload; transmitted MSB-first starting at bit len-1
len  input  $clog2(DATA_W+1)  number of payload bits to send (0..DATA_W)
ready  output  1  high in IDLE; a start is accepted at a rising edge where start&&ready
busy  output  1  high while a frame is on the wire
dataOut  output  1  serial line, registered; idles at 0
frameDone  output  1  one-cycle pulse when a frame completes

Behaviour:
- Interface reset: reset is asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, dataOut=0, ready=1, busy=0, frameDone=0, counters=0. Reset asserted mid-frame aborts the frame immediately: dataOut=0 and the block is in IDLE. The partial frame is not resumed.
- Accept: on the edge where start&&ready, latch data and len. A len above DATA_W is clamped to DATA_W. From the next cycle ready=0 and busy=1. A start seen while busy is ignored and not queued.
- States:
  - IDLE: dataOut=0.
  - PRE: emit 1 for PRE_LEN cycles.
  - BODY: emit payload bits.
  - STUFF: emit a single 1.
  - TRAIL: emit 0 for TRAIL_LEN cycles.
  - DONE: return to IDLE.
- Transitions:
  - IDLE to PRE on accept.
  - PRE to BODY after PRE_LEN bits. Go to TRAIL instead if len=0.
  - BODY: after emitting a 0, go to STUFF. After emitting a 1, go to the next payload bit.
  - After the last payload bit: to STUFF if that bit was 0, else to TRAIL.
  - STUFF to BODY if payload bits remain, else to TRAIL.
  - TRAIL to IDLE after TRAIL_LEN bits.
- Latency: the first preamble bit appears on dataOut in the cycle after the accept edge.
- Frame length N = PRE_LEN + len + Z + TRAIL_LEN cycles, where Z is the count of zeros among the sent payload bits.
- Completion: at the edge ending the last trailer bit, the block returns to IDLE, ready=1, busy=0. frameDone=1 for exactly that one following cycle. A start in that same cycle is accepted, giving back-to-back frames with no extra gap.
- Counters: the bit index counts down from len-1. Preamble and trailer counters are sized with $clog2 of their parameter plus 1. No wrap-around is reachable.
- The data and len inputs may change freely after accept; the latched copies are used.

Optional Feature:
KNL_TX_PARITY_EN:
- Defined: after the last payload bit, one even-parity bit over the sent payload bits is emitted, then TRAIL. The parity bit is subject to the same stuffing rule: a 0 parity bit is followed by a stuffed 1. N grows by 1, plus 1 more if parity=0. With len=0 the parity bit is 0 and is sent and stuffed.
- Undefined: no parity bit; N as given above.

Test Plan:
- Reset then idle 10 cycles -> dataOut=0, ready=1, busy=0, frameDone never asserts.
- data=8'hA5, len=8 -> dataOut 1111 101101011011 000 (19 cycles); busy high for those 19 cycles; frameDone pulses in cycle 20.
- data=x, len=0 -> 1111 000 (7 cycles); then frameDone pulse; a start in the frameDone cycle begins the next preamble in the following cycle.
- Frame in progress with start held high -> ignored until ready; reset pulled low during BODY -> dataOut=0 asynchronously, IDLE; the next frame is correct.
- Loopback into the KNL detector, data=8'h00, len=8 -> 1111 + (01)x8 + 000.
  - begP rises after the 4th preamble bit and stays high through the payload.
  - endP pulses exactly once per frame.
- With KNL_TX_PARITY_EN, data=8'h03, len=8:
  - Payload bits 0,0,0,0,0,0,1,1 are sent stuffed as 01 01 01 01 01 01 1 1.
  - Parity=0, emitted as 01.
  - Total frame is 4+14+2+3=23 cycles.
